// File: rtl/sobel_pkg.sv
// Purpose: shared types and FSM helper for the Sobel two-line buffer controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sobel_pkg;

    localparam int PIX_W = 8;

    // Row class of an accepted pixel: ROW0/ROW1 lack one or both history rows.
    typedef enum logic [1:0] {
        ROW0   = 2'd0,
        ROW1   = 2'd1,
        STEADY = 2'd2
    } lb_state_e;

    // One vertical window column at the default pixel width.
    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } lb_col_t;

    // Next row class after an accepted pixel; the line end moves through the
    // priming rows, only the frame end returns to ROW0.
    function automatic lb_state_e lb_next_state(input lb_state_e cur,
                                                input logic      line_end,
                                                input logic      frame_end);
        lb_state_e nxt;
        nxt = cur;
        case (cur)
            ROW0:    if (line_end)  nxt = ROW1;
            ROW1:    if (line_end)  nxt = STEADY;
            STEADY:  if (frame_end) nxt = ROW0;
            default: nxt = ROW0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync_ram_block.sv
// Purpose: simple dual-port RAM, one write port and two registered read ports.
// Latency: 1 clk from rd_en to data out; read data holds while rd_en is low.
// Backpressure: none; the owner gates rd_en to hold the read data.
module sync_ram_block #(
    parameter int WIDTH_P    = 16,
    parameter int DEPTH_P    = 640,
    parameter     filename_p = "",
    localparam int AW_P      = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               wr_en_i,
    input  logic [AW_P-1:0]    wr_addr_i,
    input  logic [WIDTH_P-1:0] wr_data_i,
    input  logic               rd_en_a_i,
    input  logic [AW_P-1:0]    rd_addr_a_i,
    output logic [WIDTH_P-1:0] data_a_o,
    input  logic               rd_en_b_i,
    input  logic [AW_P-1:0]    rd_addr_b_i,
    output logic [WIDTH_P-1:0] data_b_o
);

    // Contents are never preloaded; a non-empty file name is a build error.
    if (filename_p != "") begin : g_preload_unsupported
        $error("sync_ram_block: memory preload is not supported");
    end

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [WIDTH_P-1:0] data_a_q;
    logic [WIDTH_P-1:0] data_b_q;

    // Write port; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read ports; output holds whenever its enable is low.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            if (rd_en_a_i) data_a_q <= mem_q[rd_addr_a_i];
            if (rd_en_b_i) data_b_q <= mem_q[rd_addr_b_i];
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/sobel_linebuf_ctrl.sv
// Purpose: runs one RAM as a two-line buffer, emitting {row y-2, y-1, y} per pixel.
// Latency: 2 clk accept -> valid_o, 1 pixel/clk sustained.
// Backpressure: ready_o drops only when stage 1 is full and the output is stalled.
// Build option: SOBEL_LB_BORDER_REPLICATE_EN replicates edge rows instead of zeroing.
module sobel_linebuf_ctrl
    import sobel_pkg::*;
#(
    parameter int PIX_W_P   = PIX_W,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [PIX_W_P-1:0]           pix_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [PIX_W_P-1:0]           top_o,
    output logic [PIX_W_P-1:0]           mid_o,
    output logic [PIX_W_P-1:0]           bot_o,
    output logic [$clog2(LINE_W_P)-1:0]  x_o,
    output logic [$clog2(FRAME_H_P)-1:0] y_o,
    output logic                         eol_o,
    output logic                         eof_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    localparam int XW = $clog2(LINE_W_P);
    localparam int YW = $clog2(FRAME_H_P);
    localparam int RW = 2 * PIX_W_P;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_W_P - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H_P - 1);

    typedef struct packed {
        logic [PIX_W_P-1:0] top;
        logic [PIX_W_P-1:0] mid;
        logic [PIX_W_P-1:0] bot;
    } col_t;

    // Input-side position and row class
    logic [XW-1:0] col_cnt_q, col_cnt_d;
    logic [YW-1:0] row_cnt_q, row_cnt_d;
    lb_state_e     state_q;
    logic          last_col;
    logic          last_row;

    // Stage 1: pixel waiting for its RAM read data
    logic               v1_q;
    logic [PIX_W_P-1:0] pix1_q;
    logic [XW-1:0]      x1_q;
    logic [YW-1:0]      y1_q;
    lb_state_e          st1_q;

    // Output register
    logic          valid_q;
    col_t          col_q, col_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          eol_q;
    logic          eof_q;

    // RAM side
    logic [RW-1:0]      ram_data_a;
    logic [RW-1:0]      ram_b_unused;
    logic [PIX_W_P-1:0] ram_mid;
    logic [PIX_W_P-1:0] ram_top;

    logic accept;
    logic advance;

    assign advance = v1_q && (!valid_q || ready_i);
    assign ready_o = !v1_q || advance;
    assign accept  = valid_i && ready_o;

    assign last_col = (col_cnt_q == X_LAST);
    assign last_row = (row_cnt_q == Y_LAST);

    // Word layout: upper half is row y-1, lower half is row y-2.
    assign ram_mid = ram_data_a[RW-1:PIX_W_P];
    assign ram_top = ram_data_a[PIX_W_P-1:0];

    // S0 reads the column being accepted while S1 writes the previous column;
    // the addresses always differ because a line has at least two pixels.
    sync_ram_block #(
        .WIDTH_P    (RW),
        .DEPTH_P    (LINE_W_P),
        .filename_p ("")
    ) u_ram (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .wr_en_i     (advance),
        .wr_addr_i   (x1_q),
        .wr_data_i   ({pix1_q, ram_mid}),
        .rd_en_a_i   (accept),
        .rd_addr_a_i (col_cnt_q),
        .data_a_o    (ram_data_a),
        .rd_en_b_i   (1'b0),
        .rd_addr_b_i ('0),
        .data_b_o    (ram_b_unused)
    );

    // Raster position of the next pixel to be accepted.
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (accept) begin
            if (last_col) begin
                col_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + YW'(1);
            end else begin
                col_cnt_d = col_cnt_q + XW'(1);
            end
        end
    end

    // Position counters.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Row-class FSM, stepped by every accepted pixel.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ROW0;
        end else if (accept) begin
            state_q <= lb_next_state(state_q, last_col, last_col && last_row);
        end
    end

    // Stage 1 holds the accepted pixel until the output register can take it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            v1_q   <= 1'b0;
            pix1_q <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            st1_q  <= ROW0;
        end else if (accept) begin
            v1_q   <= 1'b1;
            pix1_q <= pix_i;
            x1_q   <= col_cnt_q;
            y1_q   <= row_cnt_q;
            st1_q  <= state_q;
        end else if (advance) begin
            v1_q   <= 1'b0;
        end
    end

    // Column assembly: rows not yet in the buffer are masked so stale RAM never leaks.
    always_comb begin
        col_d     = '0;
        col_d.bot = pix1_q;
        case (st1_q)
            ROW0: begin
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
                col_d.top = pix1_q;
                col_d.mid = pix1_q;
`else
                col_d.top = '0;
                col_d.mid = '0;
`endif
            end
            ROW1: begin
                col_d.mid = ram_mid;
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
                col_d.top = ram_mid;
`else
                col_d.top = '0;
`endif
            end
            default: begin
                col_d.top = ram_top;
                col_d.mid = ram_mid;
            end
        endcase
    end

    // Output register: loads on advance, holds while stalled, drains on ready_i.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            col_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (advance) begin
            valid_q <= 1'b1;
            col_q   <= col_d;
            x_q     <= x1_q;
            y_q     <= y1_q;
            eol_q   <= (x1_q == X_LAST);
            eof_q   <= (x1_q == X_LAST) && (y1_q == Y_LAST);
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign top_o   = col_q.top;
    assign mid_o   = col_q.mid;
    assign bot_o   = col_q.bot;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign eol_o   = eol_q;
    assign eof_o   = eof_q;

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
module tb_sobel_linebuf_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] pix_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] top_o, mid_o, bot_o;
    logic [1:0] x_o, y_o;
    logic       eol_o, eof_o, valid_o;
    logic       ready_i = 1'b1;

    sobel_linebuf_ctrl #(
        .PIX_W_P   (8),
        .LINE_W_P  (W),
        .FRAME_H_P (H)
    ) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .pix_i   (pix_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .top_o   (top_o),
        .mid_o   (mid_o),
        .bot_o   (bot_o),
        .x_o     (x_o),
        .y_o     (y_o),
        .eol_o   (eol_o),
        .eof_o   (eof_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic       eol;
        logic       eof;
    } vec_t;

    vec_t tbl [N];
    vec_t outq [$];
    vec_t prev_out;
    bit   prev_stall = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_acc_cyc = -1;
    int   first_vld_cyc = -1;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected column for the pixel at (x,y); pixel value is 16*y+x.
    function automatic vec_t exp_vec(input int x, input int y);
        vec_t v;
        v.x   = x;
        v.y   = y;
        v.bot = 8'(16 * y + x);
        if (y == 0) begin
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
            v.top = v.bot;
            v.mid = v.bot;
`else
            v.top = 8'h00;
            v.mid = 8'h00;
`endif
        end else if (y == 1) begin
            v.mid = 8'(x);
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
            v.top = v.mid;
`else
            v.top = 8'h00;
`endif
        end else begin
            v.top = 8'(16 * (y - 2) + x);
            v.mid = 8'(16 * (y - 1) + x);
        end
        v.eol = (x == W - 1);
        v.eof = (x == W - 1) && (y == H - 1);
        return v;
    endfunction

    function automatic vec_t cur_out();
        vec_t v;
        v.x   = int'(x_o);
        v.y   = int'(y_o);
        v.top = top_o;
        v.mid = mid_o;
        v.bot = bot_o;
        v.eol = eol_o;
        v.eof = eof_o;
        return v;
    endfunction

    function automatic bit same(input vec_t a, input vec_t b);
        return (a.x == b.x) && (a.y == b.y) && (a.top == b.top) && (a.mid == b.mid) &&
               (a.bot == b.bot) && (a.eol == b.eol) && (a.eof == b.eof);
    endfunction

    function automatic logic [7:0] pix_of(input int i);
        return 8'(16 * ((i / W) % H) + (i % W));
    endfunction

    // Output monitor: capture handshakes and verify hold-while-stalled.
    always @(negedge clk_i) begin
        vec_t c;
        if (mon_en) begin
            c = cur_out();
            if (prev_stall) begin
                checks++;
                if (!valid_o || !same(c, prev_out)) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b got x=%0d y=%0d %h/%h/%h, held x=%0d y=%0d %h/%h/%h",
                             valid_o, c.x, c.y, c.top, c.mid, c.bot,
                             prev_out.x, prev_out.y, prev_out.top, prev_out.mid, prev_out.bot);
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_out   = c;
            if (valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (valid_o && ready_i) outq.push_back(c);
        end
    end

    task automatic drive(input int n, input bit rnd_v, input bit rnd_r);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 4000) begin
            @(posedge clk_i);
            #1;
            budget++;
            ready_i = rnd_r ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd_v && $urandom_range(0, 2) == 0) begin
                valid_i = 1'b0;
            end else begin
                valid_i = 1'b1;
                pix_i   = pix_of(idx);
            end
            @(negedge clk_i);
            if (valid_i && ready_o) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                idx++;
            end
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0d, required %0d", idx, n);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int n);
        int b = 0;
        while (outq.size() < n && b < 200) begin
            @(negedge clk_i);
            b++;
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if (outq.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d outputs, required %0d", name, outq.size(), n);
        end
    endtask

    task automatic check_frames(input string name, input int frames);
        for (int i = 0; i < frames * N; i++) begin
            vec_t e;
            vec_t a;
            e = tbl[i % N];
            checks++;
            if (i >= outq.size()) begin
                errors++;
                $display("FAIL %s[%0d]: missing output, required x=%0d y=%0d", name, i, e.x, e.y);
            end else begin
                a = outq[i];
                if (!same(a, e)) begin
                    errors++;
                    $display("FAIL %s[%0d]: got x=%0d y=%0d %h/%h/%h eol=%0b eof=%0b, required x=%0d y=%0d %h/%h/%h eol=%0b eof=%0b",
                             name, i, a.x, a.y, a.top, a.mid, a.bot, a.eol, a.eof,
                             e.x, e.y, e.top, e.mid, e.bot, e.eol, e.eof);
                end
            end
        end
    endtask

    task automatic check_col(input string name, input int i,
                             input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
        checks++;
        if (i >= outq.size()) begin
            errors++;
            $display("FAIL %s: output %0d missing", name, i);
        end else if (outq[i].top != t || outq[i].mid != m || outq[i].bot != b) begin
            errors++;
            $display("FAIL %s: got %h/%h/%h, required %h/%h/%h",
                     name, outq[i].top, outq[i].mid, outq[i].bot, t, m, b);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (valid_o !== 1'b0 || x_o !== 2'd0 || y_o !== 2'd0 || top_o !== 8'h00 ||
            mid_o !== 8'h00 || bot_o !== 8'h00 || eol_o !== 1'b0 || eof_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%0b x=%0d y=%0d %h/%h/%h eol=%0b eof=%0b, required all 0",
                     name, valid_o, x_o, y_o, top_o, mid_o, bot_o, eol_o, eof_o);
        end
    endtask

    task automatic start_capture();
        outq.delete();
        prev_stall    = 1'b0;
        first_acc_cyc = -1;
        first_vld_cyc = -1;
        mon_en        = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) tbl[i] = exp_vec(i % W, i / W);

        // Reset state
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        check_idle("reset_state");
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b, required 1", ready_o);
        end

        // Test 1: one frame at full rate
        start_capture();
        drive(N, 1'b0, 1'b0);
        wait_drain("t1", N);
        check_frames("t1", 1);
        checks++;
        if (first_vld_cyc - first_acc_cyc != 2) begin
            errors++;
            $display("FAIL t1_latency: got %0d clk, required 2", first_vld_cyc - first_acc_cyc);
        end
        check_col("t1_x1y2", 2 * W + 1, 8'h01, 8'h11, 8'h21);
        check_col("t1_x1y3", 3 * W + 1, 8'h11, 8'h21, 8'h31);

        // Test 2: border rows
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
        check_col("t2_x2y1", 1 * W + 2, 8'h02, 8'h02, 8'h12);
        check_col("t2_x3y0", 3, 8'h03, 8'h03, 8'h03);
`else
        check_col("t2_x2y1", 1 * W + 2, 8'h00, 8'h02, 8'h12);
        check_col("t2_x3y0", 3, 8'h00, 8'h00, 8'h03);
`endif

        // Test 3: random valid_i and ready_i
        start_capture();
        drive(N, 1'b1, 1'b1);
        wait_drain("t3", N);
        check_frames("t3", 1);

        // Test 4: two frames back to back, second re-primes over stale RAM
        start_capture();
        drive(2 * N, 1'b0, 1'b0);
        wait_drain("t4", 2 * N);
        check_frames("t4", 2);

        // Test 5: reset in the middle of row 2
        start_capture();
        drive(2 * W + 2, 1'b0, 1'b0);
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        check_idle("t5_after_reset");
        start_capture();
        drive(N, 1'b0, 1'b0);
        wait_drain("t5", N);
        checks++;
        if (outq.size() == 0 || outq[0].x != 0 || outq[0].y != 0) begin
            errors++;
            $display("FAIL t5_first_pos: got size=%0d x=%0d y=%0d, required x=0 y=0",
                     outq.size(), outq.size() ? outq[0].x : -1, outq.size() ? outq[0].y : -1);
        end
`ifdef SOBEL_LB_BORDER_REPLICATE_EN
        check_col("t5_x2y0", 2, 8'h02, 8'h02, 8'h02);
`else
        check_col("t5_x2y0", 2, 8'h00, 8'h00, 8'h02);
`endif
        check_frames("t5", 1);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
